// File: rtl/painterengine_gpu_dma_writer_scheduler.sv
// Shares one 4-channel GPU DMA writer between four requesters: round-robin grant,
// parameter latch, writer reset/run sequencing, and a RUN watchdog.
module painterengine_gpu_dma_writer_scheduler #(
  parameter int unsigned PARAM_RESET_CYCLES   = 2,
  parameter int unsigned PARAM_WATCHDOG_WIDTH = 24
) (
  input  logic         i_wire_clock,
  input  logic         i_wire_resetn,
  input  logic [3:0]   i_wire_req,
  input  logic [127:0] i_wire_req_address,
  input  logic [127:0] i_wire_req_length,
  output logic [3:0]   o_wire_ack,
  output logic [3:0]   o_wire_job_done,
  output logic [3:0]   o_wire_job_error,
  output logic [2:0]   o_wire_error_type,
  output logic         o_wire_busy,
  output logic         o_wire_writer_resetn,
  output logic [3:0]   o_wire_writer_router,
  output logic [127:0] o_wire_writer_address,
  output logic [127:0] o_wire_writer_length,
  input  logic         i_wire_writer_done,
  input  logic         i_wire_writer_error,
  input  logic [2:0]   i_wire_writer_error_type
);

  localparam int unsigned NUM_CH    = 4;
  localparam int unsigned CH_W      = 2;
  localparam int unsigned SLOT_W    = 32;
  localparam int unsigned BUS_W     = NUM_CH * SLOT_W;
  localparam int unsigned ETYPE_W   = 3;
  localparam int unsigned WD_W      = PARAM_WATCHDOG_WIDTH;
  localparam int unsigned RST_CNT_W = $clog2(PARAM_RESET_CYCLES + 1);

  localparam logic [WD_W-1:0]      WD_MAX        = '1;
  localparam logic [RST_CNT_W-1:0] RST_CNT_LAST  = RST_CNT_W'(PARAM_RESET_CYCLES - 1);
  localparam logic [ETYPE_W-1:0]   ETYPE_WATCHDOG = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GRANT    = 2'd1,
    ST_RUN      = 2'd2,
    ST_COMPLETE = 2'd3
  } state_t;

  state_t                 state_q,   state_d;
  logic [CH_W-1:0]        rr_q,      rr_d;
  logic [CH_W-1:0]        ch_q,      ch_d;
  logic [RST_CNT_W-1:0]   rst_cnt_q, rst_cnt_d;
  logic [WD_W-1:0]        wd_q,      wd_d;
  logic [NUM_CH-1:0]      ack_q,     ack_d;
  logic [NUM_CH-1:0]      done_q,    done_d;
  logic [NUM_CH-1:0]      err_q,     err_d;
  logic [ETYPE_W-1:0]     etype_q,   etype_d;
  logic                   busy_q,    busy_d;
  logic                   wresetn_q, wresetn_d;
  logic [NUM_CH-1:0]      router_q,  router_d;
  logic [BUS_W-1:0]       addr_q,    addr_d;
  logic [BUS_W-1:0]       len_q,     len_d;

  logic                   pick_valid;
  logic [CH_W-1:0]        pick_ch;
  logic [CH_W-1:0]        cand;

  // Round-robin pick: nearest set request after rr, wrapping; walked far-to-near so nearest wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_ch    = '0;
    cand       = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      cand = rr_q + CH_W'(k);
      if (i_wire_req[cand]) begin
        pick_valid = 1'b1;
        pick_ch    = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    ch_d      = ch_q;
    rst_cnt_d = rst_cnt_q;
    wd_d      = wd_q;
    ack_d     = '0;
    done_d    = '0;
    err_d     = '0;
    etype_d   = etype_q;
    wresetn_d = wresetn_q;
    router_d  = router_q;
    addr_d    = addr_q;
    len_d     = len_q;

    case (state_q)
      ST_IDLE: begin
        wresetn_d = 1'b0;
        router_d  = '0;
        if (pick_valid) begin
          state_d   = ST_GRANT;
          ch_d      = pick_ch;
          rst_cnt_d = '0;
          ack_d     = NUM_CH'(1) << pick_ch;
          router_d  = NUM_CH'(1) << pick_ch;
          addr_d    = '0;
          len_d     = '0;
          addr_d[pick_ch*SLOT_W +: SLOT_W] = i_wire_req_address[pick_ch*SLOT_W +: SLOT_W];
          len_d[pick_ch*SLOT_W +: SLOT_W]  = i_wire_req_length[pick_ch*SLOT_W +: SLOT_W];
        end
      end

      ST_GRANT: begin
        if (rst_cnt_q == RST_CNT_LAST) begin
          state_d   = ST_RUN;
          wresetn_d = 1'b1;
          wd_d      = '0;
        end else begin
          rst_cnt_d = rst_cnt_q + RST_CNT_W'(1);
        end
      end

      ST_RUN: begin
        wd_d = wd_q + WD_W'(1);
        // Priority on simultaneous events: writer error, then done, then watchdog.
        if (i_wire_writer_error || i_wire_writer_done || (wd_q == WD_MAX)) begin
          state_d   = ST_COMPLETE;
          wresetn_d = 1'b0;
          router_d  = '0;
          addr_d    = '0;
          len_d     = '0;
          rr_d      = ch_q;
          if (i_wire_writer_error) begin
            err_d   = NUM_CH'(1) << ch_q;
            etype_d = i_wire_writer_error_type;
          end else if (i_wire_writer_done) begin
            done_d  = NUM_CH'(1) << ch_q;
          end else begin
            err_d   = NUM_CH'(1) << ch_q;
            etype_d = ETYPE_WATCHDOG;
          end
        end
      end

      ST_COMPLETE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d   = ST_IDLE;
        wresetn_d = 1'b0;
        router_d  = '0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      state_q   <= ST_IDLE;
      rr_q      <= CH_W'(3);
      ch_q      <= '0;
      rst_cnt_q <= '0;
      wd_q      <= '0;
      ack_q     <= '0;
      done_q    <= '0;
      err_q     <= '0;
      etype_q   <= '0;
      busy_q    <= 1'b0;
      wresetn_q <= 1'b0;
      router_q  <= '0;
      addr_q    <= '0;
      len_q     <= '0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      ch_q      <= ch_d;
      rst_cnt_q <= rst_cnt_d;
      wd_q      <= wd_d;
      ack_q     <= ack_d;
      done_q    <= done_d;
      err_q     <= err_d;
      etype_q   <= etype_d;
      busy_q    <= busy_d;
      wresetn_q <= wresetn_d;
      router_q  <= router_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
    end
  end

  assign o_wire_ack            = ack_q;
  assign o_wire_job_done       = done_q;
  assign o_wire_job_error      = err_q;
  assign o_wire_error_type     = etype_q;
  assign o_wire_busy           = busy_q;
  assign o_wire_writer_resetn  = wresetn_q;
  assign o_wire_writer_router  = router_q;
  assign o_wire_writer_address = addr_q;
  assign o_wire_writer_length  = len_q;

endmodule

// File: tb/tb_painterengine_gpu_dma_writer_scheduler.sv
// Randomized job-level bench for the DMA writer scheduler against a transaction model.
module tb_painterengine_gpu_dma_writer_scheduler;

  localparam int unsigned RC  = 2;
  localparam int unsigned WDW = 4;

  localparam int K_DONE = 0;
  localparam int K_ERR  = 1;
  localparam int K_BOTH = 2;
  localparam int K_WDOG = 3;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic [3:0]   req = '0;
  logic [127:0] req_addr = '0;
  logic [127:0] req_len = '0;
  logic [3:0]   ack, jdone, jerr, router;
  logic [2:0]   etype;
  logic         busy, wrn;
  logic [127:0] waddr, wlen;
  logic         wdone = 1'b0;
  logic         werr = 1'b0;
  logic [2:0]   wtype = '0;

  int errors = 0;
  int checks = 0;
  int rr_m = 3;
  logic [2:0] etype_m = '0;

  painterengine_gpu_dma_writer_scheduler #(
    .PARAM_RESET_CYCLES  (RC),
    .PARAM_WATCHDOG_WIDTH(WDW)
  ) dut (
    .i_wire_clock            (clk),
    .i_wire_resetn           (rstn),
    .i_wire_req              (req),
    .i_wire_req_address      (req_addr),
    .i_wire_req_length       (req_len),
    .o_wire_ack              (ack),
    .o_wire_job_done         (jdone),
    .o_wire_job_error        (jerr),
    .o_wire_error_type       (etype),
    .o_wire_busy             (busy),
    .o_wire_writer_resetn    (wrn),
    .o_wire_writer_router    (router),
    .o_wire_writer_address   (waddr),
    .o_wire_writer_length    (wlen),
    .i_wire_writer_done      (wdone),
    .i_wire_writer_error     (werr),
    .i_wire_writer_error_type(wtype)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Nearest requesting channel after the last served one, wrapping.
  function automatic int pick(input logic [3:0] m, input int rr);
    for (int k = 1; k <= 4; k++) if (m[(rr + k) % 4]) return (rr + k) % 4;
    return 0;
  endfunction

  function automatic logic [127:0] ctrl_vec();
    return 128'({ack, jdone, jerr, etype, busy, wrn, router});
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0; req = '0; wdone = 1'b0; werr = 1'b0;
    @(negedge clk);
    check("reset_ctrl", ctrl_vec(), 128'(0));
    check("reset_addr", waddr | wlen, 128'(0));
    rstn = 1'b1;
    rr_m = 3; etype_m = '0;
    @(negedge clk);
    check("reset_idle", ctrl_vec(), 128'(0));
  endtask

  task automatic run_job(input logic [3:0] mask, input bit hold, input int kind,
                         input int d, input logic [2:0] typ);
    int c, n, exp_n;
    bit got;
    logic [3:0] oh, exp_done, exp_err;
    logic [127:0] ea, el;
    c  = pick(mask, rr_m);
    oh = 4'(1) << c;
    ea = '0; el = '0;
    ea[c*32 +: 32] = req_addr[c*32 +: 32];
    el[c*32 +: 32] = req_len[c*32 +: 32];

    req = mask;
    n = 0;
    do begin @(negedge clk); n++; end while (ack == 4'b0 && n < 20);
    check("ack_latency", 128'(n), 128'(1));
    check("ack", 128'(ack), 128'(oh));
    check("router", 128'(router), 128'(oh));
    check("address", waddr, ea);
    check("length", wlen, el);
    check("wresetn_grant", 128'({busy, wrn}), 128'(2'b10));
    if (!hold) req = mask & ~oh;

    n = 0;
    do begin
      @(negedge clk); n++;
      if (n == 1) check("ack_pulse", 128'(ack), 128'(0));
    end while (!wrn && n < 20);
    check("reset_cycles", 128'(n), 128'(RC));
    check("router_run", 128'(router), 128'(oh));
    check("address_run", waddr, ea);

    exp_done = (kind == K_DONE) ? oh : 4'b0;
    exp_err  = (kind == K_DONE) ? 4'b0 : oh;
    exp_n    = (kind == K_WDOG) ? (2 ** WDW) : d + 1;
    if (kind == K_ERR || kind == K_BOTH) etype_m = typ;
    if (kind == K_WDOG) etype_m = 3'b111;

    n = 0; got = 1'b0;
    while (n < 64 && !got) begin
      if (kind != K_WDOG && n == d) begin
        wdone = (kind == K_DONE || kind == K_BOTH);
        werr  = (kind != K_DONE);
        wtype = typ;
      end
      @(negedge clk); n++;
      if ((jdone | jerr) != 4'b0) got = 1'b1;
    end
    check("run_latency", 128'(n), 128'(exp_n));
    check("job_done", 128'(jdone), 128'(exp_done));
    check("job_error", 128'(jerr), 128'(exp_err));
    check("error_type", 128'(etype), 128'(etype_m));
    check("complete_ctrl", 128'({busy, wrn}), 128'(2'b10));
    wdone = 1'b0; werr = 1'b0;
    rr_m = c;

    @(negedge clk);
    check("idle_pulses", 128'({jdone, jerr, ack}), 128'(0));
    check("idle_state", 128'({busy, wrn, router}), 128'(0));
    check("idle_slots", waddr | wlen, 128'(0));
    check("type_held", 128'(etype), 128'(etype_m));
  endtask

  task automatic abort_job(input logic [3:0] mask, input int extra);
    int n;
    req = mask;
    n = 0;
    do begin @(negedge clk); n++; end while (ack == 4'b0 && n < 20);
    check("abort_ack", 128'(ack), 128'(4'(1) << pick(mask, rr_m)));
    req = '0;
    n = 0;
    do begin @(negedge clk); n++; end while (!wrn && n < 20);
    check("abort_run", 128'(wrn), 128'(1));
    repeat (extra) @(negedge clk);
    #2 rstn = 1'b0;
    #1 check("async_ctrl", ctrl_vec(), 128'(0));
    check("async_slots", waddr | wlen, 128'(0));
    wdone = 1'b1;
    @(negedge clk);
    check("held_ctrl", ctrl_vec(), 128'(0));
    wdone = 1'b0;
    rstn = 1'b1;
    rr_m = 3; etype_m = '0;
    repeat (2) begin
      @(negedge clk);
      check("no_pulse", 128'({jdone, jerr, busy}), 128'(0));
    end
  endtask

  initial begin
    int r;
    logic [3:0] m;
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    check("por_ctrl", ctrl_vec(), 128'(0));
    check("por_slots", waddr | wlen, 128'(0));
    rstn = 1'b1;
    @(negedge clk);

    // Single job on channel 2
    req_addr[95:64] = 32'h1000_0000;
    req_len[95:64]  = 32'd64;
    run_job(4'b0100, 1'b0, K_DONE, 3, 3'd0);

    // Round-robin with all requests held
    do_reset();
    for (int i = 0; i < 6; i++) run_job(4'b1111, 1'b1, K_DONE, i, 3'd0);
    run_job(4'b1001, 1'b0, K_DONE, 1, 3'd0);

    // Writer error, then a clean job keeps the error code
    do_reset();
    run_job(4'b0010, 1'b0, K_ERR, 2, 3'b010);
    run_job(4'b0001, 1'b0, K_DONE, 0, 3'b001);

    // Watchdog expiry, done at the expiry cycle, simultaneous done+error
    run_job(4'b1000, 1'b0, K_WDOG, 0, 3'd0);
    run_job(4'b0010, 1'b0, K_DONE, 15, 3'd0);
    run_job(4'b0100, 1'b0, K_BOTH, 4, 3'b100);

    // Reset mid-run, then rr restarts from 3
    abort_job(4'b0100, 3);
    run_job(4'b0101, 1'b0, K_DONE, 2, 3'd0);

    for (int i = 0; i < 40; i++) begin
      m = 4'($urandom_range(1, 15));
      req_addr = {$urandom, $urandom, $urandom, $urandom};
      req_len  = {$urandom, $urandom, $urandom, $urandom};
      r = int'($urandom_range(0, 19));
      if (r == 19) abort_job(m, int'($urandom_range(0, 6)));
      else run_job(m, 1'($urandom_range(0, 1)),
                   (r < 10) ? K_DONE : (r < 14) ? K_ERR : (r < 17) ? K_BOTH : K_WDOG,
                   int'($urandom_range(0, 15)), 3'($urandom_range(0, 4)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
